// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch path: geometry constants, the
// scheduler state encoding and the ROM address packing helper.
package sprite_pkg;

  localparam int SPR_DIM = 16;
  localparam int ROM_AW  = 10;
  localparam int IMG_W   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

  // ROM layout is image-major, then row, then column: {img, row, col}.
  function automatic logic [ROM_AW-1:0] pack_rom_addr(
    input logic [IMG_W-1:0] img,
    input logic [3:0]       row,
    input logic [3:0]       col
  );
    return {img, row, col};
  endfunction

endpackage

// File: rtl/sprite_row_calc.sv
// Combinational vertical hit test for one sprite slot. The row offset is
// taken modulo 1024 so sprites straddling the top of the frame wrap.
module sprite_row_calc #(
  parameter int SPR_DIM = 16
) (
  input  logic [9:0] line_i,
  input  logic [9:0] y_i,
  input  logic       en_i,
  output logic       hit_o,
  output logic [3:0] row_o
);

  logic [9:0] dy_s;

  assign dy_s  = line_i - y_i;
  assign hit_o = en_i && (dy_s < 10'(SPR_DIM));
  assign row_o = dy_s[3:0];

endmodule

// File: rtl/sprite_fetch_sched.sv
// Per-scanline sprite fetch scheduler: latches the attribute table on
// line_start, walks the slots in order and streams each hit sprite's row
// from the shared image ROM into the line buffers, then reports the hit
// mask with done.
// Optional build macro: SPRITE_FLIP_EN adds spr_flip_i for horizontal
// mirroring; cycle timing is the same in both builds.
module sprite_fetch_sched #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_DIM     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_start_i,
  input  logic [9:0]                next_line_i,
  input  logic [NUM_SPRITES-1:0]    spr_en_i,
`ifdef SPRITE_FLIP_EN
  input  logic [NUM_SPRITES-1:0]    spr_flip_i,
`endif
  input  logic [10*NUM_SPRITES-1:0] spr_y_i,
  input  logic [2*NUM_SPRITES-1:0]  spr_img_i,
  output logic [9:0]                rom_addr_o,
  input  logic [7:0]                rom_rdata_i,
  output logic                      lb_we_o,
  output logic [1:0]                lb_sel_o,
  output logic [3:0]                lb_addr_o,
  output logic [7:0]                lb_wdata_o,
  output logic [NUM_SPRITES-1:0]    hit_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overrun_o
);

  import sprite_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(NUM_SPRITES - 1);
  localparam logic [3:0] COL_LAST = 4'(SPR_DIM - 1);

  sched_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [3:0]   col_q, col_d;
  logic [3:0]   row_q, row_d;
  logic [NUM_SPRITES-1:0] hit_acc_q, hit_acc_d;

  // Attribute shadows captured when a round is accepted.
  logic [9:0]                sh_line_q;
  logic [NUM_SPRITES-1:0]    sh_en_q;
  logic [10*NUM_SPRITES-1:0] sh_y_q;
  logic [2*NUM_SPRITES-1:0]  sh_img_q;
`ifdef SPRITE_FLIP_EN
  logic [NUM_SPRITES-1:0]    sh_flip_q;
`endif

  logic [ROM_AW-1:0]      rom_addr_q, rom_addr_d;
  logic                   lb_we_q, lb_we_d;
  logic [1:0]             lb_sel_q, lb_sel_d;
  logic [3:0]             lb_addr_q, lb_addr_d;
  logic [NUM_SPRITES-1:0] hit_q, hit_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;

  logic                   latch_s;
  logic [9:0]             y_cur_s;
  logic [IMG_W-1:0]       img_cur_s;
  logic                   en_cur_s;
  logic                   flip_cur_s;
  logic                   cur_hit_s;
  logic [3:0]             cur_row_s;
  logic [3:0]             fetch_col_s;
  logic [3:0]             addr_col_s;
  logic [3:0]             addr_row_s;
  logic [NUM_SPRITES-1:0] slot_onehot_s;

  // Select the shadowed attributes of the slot currently being served.
  always_comb begin
    y_cur_s    = 10'd0;
    img_cur_s  = '0;
    en_cur_s   = 1'b0;
    flip_cur_s = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (idx_q == 2'(i)) begin
        y_cur_s   = sh_y_q[i*10 +: 10];
        img_cur_s = sh_img_q[i*IMG_W +: IMG_W];
        en_cur_s  = sh_en_q[i];
`ifdef SPRITE_FLIP_EN
        flip_cur_s = sh_flip_q[i];
`endif
      end else begin
        en_cur_s = en_cur_s;
      end
    end
  end

  sprite_row_calc #(
    .SPR_DIM (SPR_DIM)
  ) u_row_calc (
    .line_i (sh_line_q),
    .y_i    (y_cur_s),
    .en_i   (en_cur_s),
    .hit_o  (cur_hit_s),
    .row_o  (cur_row_s)
  );

  assign slot_onehot_s = {{(NUM_SPRITES-1){1'b0}}, 1'b1} << idx_q;

  // Column to present next: 0 when leaving SCAN, otherwise the following one.
  // Flipped sprites read the ROM right-to-left while the buffer fills 0..15.
  always_comb begin
    if (state_q == SCAN) begin
      fetch_col_s = 4'd0;
      addr_row_s  = cur_row_s;
    end else begin
      fetch_col_s = col_q + 4'd1;
      addr_row_s  = row_q;
    end
    addr_col_s = flip_cur_s ? (4'd15 - fetch_col_s) : fetch_col_s;
  end

  // Next-state and registered-output logic for the fetch round.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    row_d      = row_q;
    hit_acc_d  = hit_acc_q;
    rom_addr_d = rom_addr_q;
    lb_we_d    = 1'b0;
    lb_sel_d   = 2'd0;
    lb_addr_d  = 4'd0;
    hit_d      = hit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    latch_s    = 1'b0;
    overrun_d  = line_start_i && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (line_start_i) begin
          latch_s   = 1'b1;
          idx_d     = 2'd0;
          col_d     = 4'd0;
          hit_acc_d = '0;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end else begin
          busy_d = 1'b0;
        end
      end
      SCAN: begin
        if (cur_hit_s) begin
          hit_acc_d  = hit_acc_q | slot_onehot_s;
          row_d      = cur_row_s;
          col_d      = 4'd0;
          rom_addr_d = pack_rom_addr(img_cur_s, addr_row_s, addr_col_s);
          state_d    = FETCH;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      FETCH: begin
        // The pixel addressed this cycle is written next cycle.
        lb_we_d   = 1'b1;
        lb_sel_d  = idx_q;
        lb_addr_d = col_q;
        if (col_q == COL_LAST) begin
          state_d = DRAIN;
        end else begin
          col_d      = col_q + 4'd1;
          rom_addr_d = pack_rom_addr(img_cur_s, addr_row_s, addr_col_s);
        end
      end
      DRAIN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = SCAN;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        hit_d   = hit_acc_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow and output registers; reset clears everything including
  // any write still waiting in the delay stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      col_q      <= 4'd0;
      row_q      <= 4'd0;
      hit_acc_q  <= '0;
      sh_line_q  <= 10'd0;
      sh_en_q    <= '0;
      sh_y_q     <= '0;
      sh_img_q   <= '0;
`ifdef SPRITE_FLIP_EN
      sh_flip_q  <= '0;
`endif
      rom_addr_q <= '0;
      lb_we_q    <= 1'b0;
      lb_sel_q   <= 2'd0;
      lb_addr_q  <= 4'd0;
      hit_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      hit_acc_q  <= hit_acc_d;
      rom_addr_q <= rom_addr_d;
      lb_we_q    <= lb_we_d;
      lb_sel_q   <= lb_sel_d;
      lb_addr_q  <= lb_addr_d;
      hit_q      <= hit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      if (latch_s) begin
        sh_line_q <= next_line_i;
        sh_en_q   <= spr_en_i;
        sh_y_q    <= spr_y_i;
        sh_img_q  <= spr_img_i;
`ifdef SPRITE_FLIP_EN
        sh_flip_q <= spr_flip_i;
`endif
      end
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign lb_we_o    = lb_we_q;
  assign lb_sel_o   = lb_sel_q;
  assign lb_addr_o  = lb_addr_q;
  // ROM data arrives in the write cycle itself; gate it so idle cycles read 0.
  assign lb_wdata_o = lb_we_q ? rom_rdata_i : 8'h00;
  assign hit_o      = hit_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overrun_o  = overrun_q;

endmodule
